spiker_reader: RTL and testbench

- Upstream stage of the spiker result writer.
- Collects the input spike vector from software-written 32-bit input registers into a shadow buffer. On a software start it launches one inference on the spiker core with a valid/ready handshake.
- It then waits for the core's done pulse and for the result writer to be ready again before accepting the next frame.
- Sticky error flags report bad starts, writes made while busy, and core timeouts.

---
 rtl/spiker_adapter_reg_pkg.sv | 48 ++++
 rtl/spiker_reader_buf.sv | 58 +++++
 rtl/spiker_reader.sv | 145 ++++++++++++++
 tb/tb_spiker_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiker_adapter_reg_pkg.sv
// Shared types and constants for the spiker adapter register block and its reader stage.
// Holds the reader FSM encoding and the reg2hw fields that feed the reader.
package spiker_adapter_reg_pkg;

    localparam int unsigned SPK_WIDTH          = 32;
    localparam int unsigned SPK_N_SPIKES       = 784;
    localparam int unsigned SPK_TIMEOUT_CYCLES = 65535;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    localparam int unsigned N_IN_REG       = ceil_div(SPK_N_SPIKES, SPK_WIDTH);
    localparam int unsigned LAST_WORD_BITS = SPK_N_SPIKES - (N_IN_REG - 1) * SPK_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        WAIT_WR
    } reader_state_e;

    typedef struct packed {
        logic [SPK_WIDTH-1:0] q;
        logic                 qe;
    } reg2hw_spikes_in_mreg_t;

    typedef struct packed {
        logic q;
        logic qe;
    } reg2hw_control_start_t;

    typedef struct packed {
        logic q;
        logic qe;
    } reg2hw_control_clr_err_t;

    typedef struct packed {
        reg2hw_control_start_t   start;
        reg2hw_control_clr_err_t clr_err;
    } reg2hw_control_reg_t;

    typedef struct packed {
        reg2hw_spikes_in_mreg_t [N_IN_REG-1:0] spikes_in;
        reg2hw_control_reg_t                   control;
    } reg2hw_reader_t;

endpackage

// File: rtl/spiker_reader_buf.sv
// Shadow buffer for the input spike words: stores only the N_SPIKES live bits,
// tracks which words were written since the last launch, and reports a full load.
module spiker_reader_buf #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SPIKES = 784,
    parameter int unsigned N_IN_REG = 25
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [$clog2(N_IN_REG)-1:0] wr_idx_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  logic                        clr_mask_i,
    output logic [N_SPIKES-1:0]         shadow_o,
    output logic                        loaded_o
);

    localparam int unsigned PAD_W = N_IN_REG * WIDTH;

    logic [N_SPIKES-1:0]              shadow_q, shadow_d;
    logic [N_IN_REG-1:0][WIDTH-1:0]   words;
    logic [N_IN_REG-1:0]              mask_q, mask_d;
    logic                             loaded_q, loaded_d;
    logic                             idx_ok;

    assign idx_ok = 32'(wr_idx_i) < N_IN_REG;

    // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        words    = PAD_W'(shadow_q);
        mask_d   = clr_mask_i ? '0 : mask_q;
        if (wr_en_i && idx_ok) begin
            words[wr_idx_i]  = wr_data_i;
            mask_d[wr_idx_i] = 1'b1;
        end
        // Bits of the last word above N_SPIKES are dropped here, so they never become flops.
        shadow_d = N_SPIKES'(words);
        loaded_d = &mask_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: the shadow array is reset on purpose: its contents reach data_in_o and must read zero after reset.
            shadow_q <= '0;
            mask_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            loaded_q <= loaded_d;
        end
    end

    assign shadow_o = shadow_q;
    assign loaded_o = loaded_q;

endmodule

// File: rtl/spiker_reader.sv
// Reader stage ahead of the spiker result writer: launches one core inference per
// software start, waits for done and writer ready, and keeps sticky error flags.
module spiker_reader #(
    parameter int unsigned WIDTH          = spiker_adapter_reg_pkg::SPK_WIDTH,
    parameter int unsigned N_SPIKES       = spiker_adapter_reg_pkg::SPK_N_SPIKES,
    parameter int unsigned N_IN_REG       = spiker_adapter_reg_pkg::ceil_div(N_SPIKES, WIDTH),
    parameter int unsigned TIMEOUT_CYCLES = spiker_adapter_reg_pkg::SPK_TIMEOUT_CYCLES
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [$clog2(N_IN_REG)-1:0] wr_idx_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  logic                        start_i,
    input  logic                        clr_err_i,
    output logic [N_SPIKES-1:0]         data_in_o,
    output logic                        valid_o,
    input  logic                        core_ready_i,
    input  logic                        done_i,
    input  logic                        writer_ready_i,
    output logic                        busy_o,
    output logic                        loaded_o,
    output logic                        err_start_o,
    output logic                        err_overrun_o,
    output logic                        err_timeout_o
);

    import spiker_adapter_reg_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    reader_state_e       state_q, state_d;
    logic [N_SPIKES-1:0] data_in_q, data_in_d;
    logic [N_SPIKES-1:0] shadow;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_start_q, err_start_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_timeout_q, err_timeout_d;
    logic                buf_wr_en;
    logic                mask_clr;
    logic                loaded;
    logic                start_bad;
    logic                timeout_hit;
    logic                overrun;

    spiker_reader_buf #(
        .WIDTH   (WIDTH),
        .N_SPIKES(N_SPIKES),
        .N_IN_REG(N_IN_REG)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (buf_wr_en),
        .wr_idx_i  (wr_idx_i),
        .wr_data_i (wr_data_i),
        .clr_mask_i(mask_clr),
        .shadow_o  (shadow),
        .loaded_o  (loaded)
    );

    always_comb begin
        state_d     = state_q;
        data_in_d   = data_in_q;
        cnt_d       = cnt_q;
        buf_wr_en   = 1'b0;
        mask_clr    = 1'b0;
        start_bad   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                buf_wr_en = wr_en_i;
                // loaded is the registered mask, so a write in this same cycle cannot satisfy this start.
                if (start_i) begin
                    if (loaded) begin
                        state_d   = ISSUE;
                        data_in_d = shadow;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (core_ready_i) begin
                    state_d  = WAIT_DONE;
                    mask_clr = 1'b1;
                    cnt_d    = '0;
                end
            end
            WAIT_DONE: begin
                if (done_i) begin
                    state_d = WAIT_WR;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_WR: begin
                // The writer drops ready the cycle after done, so sampling from the first WAIT_WR cycle is safe.
                if (writer_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun = wr_en_i && (state_q != IDLE);

    // A new error event outranks a simultaneous clear.
    always_comb begin
        err_start_d   = (err_start_q   && !clr_err_i) || start_bad;
        err_overrun_d = (err_overrun_q && !clr_err_i) || overrun;
        err_timeout_d = (err_timeout_q && !clr_err_i) || timeout_hit;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            data_in_q     <= '0;
            cnt_q         <= '0;
            err_start_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_in_q     <= data_in_d;
            cnt_q         <= cnt_d;
            err_start_q   <= err_start_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign data_in_o     = data_in_q;
    assign valid_o       = (state_q == ISSUE);
    assign busy_o        = (state_q != IDLE);
    assign loaded_o      = loaded;
    assign err_start_o   = err_start_q;
    assign err_overrun_o = err_overrun_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_spiker_reader.sv
// Scoreboard bench for spiker_reader: a word-array model predicts each launched frame,
// and a monitor compares it at every valid/ready handshake.
module tb_spiker_reader;

    localparam int W  = 32;
    localparam int NS = 784;
    localparam int NR = 25;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wr_en_i;
    logic [4:0]    wr_idx_i;
    logic [W-1:0]  wr_data_i;
    logic          start_i;
    logic          clr_err_i;
    logic [NS-1:0] data_in_o;
    logic          valid_o;
    logic          core_ready_i;
    logic          done_i;
    logic          writer_ready_i;
    logic          busy_o;
    logic          loaded_o;
    logic          err_start_o;
    logic          err_overrun_o;
    logic          err_timeout_o;

    always #5 clk_i = ~clk_i;

    spiker_reader #(
        .WIDTH         (W),
        .N_SPIKES      (NS),
        .N_IN_REG      (NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_en_i       (wr_en_i),
        .wr_idx_i      (wr_idx_i),
        .wr_data_i     (wr_data_i),
        .start_i       (start_i),
        .clr_err_i     (clr_err_i),
        .data_in_o     (data_in_o),
        .valid_o       (valid_o),
        .core_ready_i  (core_ready_i),
        .done_i        (done_i),
        .writer_ready_i(writer_ready_i),
        .busy_o        (busy_o),
        .loaded_o      (loaded_o),
        .err_start_o   (err_start_o),
        .err_overrun_o (err_overrun_o),
        .err_timeout_o (err_timeout_o)
    );

    int total = 0;
    int bad   = 0;

    logic [NS-1:0] exp_q[$];
    logic [NS-1:0] mon_exp;
    logic [W-1:0]  m_shadow[NR];
    logic [NR-1:0] m_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Spike b comes from bit b%W of input word b/W.
    function automatic logic [NS-1:0] model_frame();
        logic [NS-1:0] f;
        for (int b = 0; b < NS; b++) f[b] = m_shadow[b / W][b % W];
        return f;
    endfunction

    task automatic model_reset();
        m_mask = '0;
        for (int i = 0; i < NR; i++) m_shadow[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_word(input int idx, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_idx_i  = idx[4:0];
        wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
        if (idx < NR) begin
            m_shadow[idx] = d;
            m_mask[idx]   = 1'b1;
        end
    endtask

    task automatic load_random(input int extra);
        int ord[NR];
        int j;
        int t;
        for (int i = 0; i < NR; i++) ord[i] = i;
        for (int i = NR - 1; i > 0; i--) begin
            j      = int'($urandom_range(i, 0));
            t      = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        for (int i = 0; i < NR; i++) write_word(ord[i], $urandom);
        for (int i = 0; i < extra; i++) write_word(int'($urandom_range(NR - 1, 0)), $urandom);
    endtask

    task automatic launch();
        logic full;
        full    = &m_mask;
        start_i = 1'b1;
        if (full) exp_q.push_back(model_frame());
        tick();
        start_i = 1'b0;
        if (full) begin
            check("start_valid", valid_o, 1);
            check("start_busy", busy_o, 1);
        end else begin
            check("bad_start_err", err_start_o, 1);
            check("bad_start_valid", valid_o, 0);
            check("bad_start_busy", busy_o, 0);
        end
    endtask

    task automatic accept(input int bp);
        for (int i = 0; i < bp; i++) begin
            core_ready_i = 1'b0;
            tick();
            check("bp_valid", valid_o, 1);
            check_frame("bp_stable", data_in_o, exp_q[$]);
        end
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        m_mask       = '0;
        check("hs_valid", valid_o, 0);
        check("hs_loaded", loaded_o, 0);
        check("hs_busy", busy_o, 1);
    endtask

    task automatic finish_frame(input int done_delay, input int wr_wait);
        for (int i = 0; i < done_delay; i++) begin
            start_i = (i == 0);
            tick();
            check("wait_done_busy", busy_o, 1);
        end
        start_i = 1'b0;
        check("start_busy_noerr", err_start_o, 0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check("wait_wr_busy", busy_o, 1);
        for (int i = 0; i < wr_wait; i++) begin
            writer_ready_i = 1'b0;
            tick();
            check("wr_wait_busy", busy_o, 1);
        end
        writer_ready_i = 1'b1;
        tick();
        writer_ready_i = 1'b0;
        check("frame_end_idle", busy_o, 0);
    endtask

    task automatic clear_errors();
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && valid_o === 1'b1 && core_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_unexpected: got handshake want none");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_frame("frame_data", data_in_o, mon_exp);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        rst_ni         = 1'b0;
        wr_en_i        = 1'b0;
        wr_idx_i       = '0;
        wr_data_i      = '0;
        start_i        = 1'b0;
        clr_err_i      = 1'b0;
        core_ready_i   = 1'b0;
        done_i         = 1'b0;
        writer_ready_i = 1'b0;
        model_reset();

        tick();
        tick();
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_loaded", loaded_o, 0);
        check("rst_err_start", err_start_o, 0);
        check("rst_err_overrun", err_overrun_o, 0);
        check("rst_err_timeout", err_timeout_o, 0);
        check_frame("rst_data", data_in_o, '0);
        rst_ni = 1'b1;
        tick();

        // Full load and launch with the fixed pattern.
        for (int i = 0; i < NR; i++) write_word(i, 32'hA5A5_0000 + 32'(i));
        check("full_loaded", loaded_o, 1);
        launch();
        check("data_word0", data_in_o[31:0], 32'hA5A5_0000);
        check("data_last16", {16'h0, data_in_o[783:768]}, 32'h0000_0018);
        accept(0);
        finish_frame(1, 1);

        // Incomplete load, out-of-range index, clear and error/clear priority.
        for (int i = 0; i < NR - 1; i++) write_word(i, $urandom);
        write_word(NR, 32'hDEAD_BEEF);
        check("oor_loaded", loaded_o, 0);
        check("oor_no_overrun", err_overrun_o, 0);
        launch();
        clear_errors();
        check("clr_err_start", err_start_o, 0);
        start_i   = 1'b1;
        clr_err_i = 1'b1;
        tick();
        start_i   = 1'b0;
        clr_err_i = 1'b0;
        check("event_beats_clr", err_start_o, 1);
        clear_errors();
        wr_en_i   = 1'b1;
        wr_idx_i  = 5'(NR - 1);
        wr_data_i = $urandom;
        start_i   = 1'b1;
        tick();
        wr_en_i              = 1'b0;
        start_i              = 1'b0;
        m_shadow[NR - 1]     = wr_data_i;
        m_mask[NR - 1]       = 1'b1;
        check("same_cycle_err", err_start_o, 1);
        check("same_cycle_valid", valid_o, 0);
        check("same_cycle_loaded", loaded_o, 1);
        clear_errors();

        // Backpressure for 10 cycles, then done exactly on the last allowed cycle.
        launch();
        accept(10);
        finish_frame(TO - 1, 2);
        check("done_at_limit_noerr", err_timeout_o, 0);

        // Overrun during WAIT_DONE, raised together with a clear.
        load_random(2);
        launch();
        accept(0);
        wr_en_i   = 1'b1;
        wr_idx_i  = 5'd3;
        wr_data_i = 32'hFFFF_FFFF;
        clr_err_i = 1'b1;
        tick();
        wr_en_i   = 1'b0;
        clr_err_i = 1'b0;
        check("overrun_flag", err_overrun_o, 1);
        check("overrun_busy", busy_o, 1);
        finish_frame(2, 0);
        load_random(0);
        write_word(3, 32'h0);
        launch();
        check("reload_word3", data_in_o[127:96], 32'h0);
        accept(0);
        finish_frame(0, 0);
        clear_errors();
        check("overrun_cleared", err_overrun_o, 0);

        // Timeout: no done for TO cycles after the handshake.
        load_random(0);
        launch();
        accept(0);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            check("to_busy", busy_o, 1);
            check("to_no_err", err_timeout_o, 0);
        end
        tick();
        check("to_idle", busy_o, 0);
        check("to_err", err_timeout_o, 1);
        clear_errors();
        check("to_cleared", err_timeout_o, 0);

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            load_random(int'($urandom_range(3, 0)));
            check("rnd_loaded", loaded_o, 1);
            launch();
            accept(int'($urandom_range(4, 0)));
            finish_frame(int'($urandom_range(TO - 1, 0)), int'($urandom_range(3, 0)));
            check("rnd_no_timeout", err_timeout_o, 0);
            check("rnd_no_overrun", err_overrun_o, 0);
        end

        // Reset while in ISSUE.
        load_random(0);
        launch();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        void'(exp_q.pop_back());
        model_reset();
        check("midrst_valid", valid_o, 0);
        check("midrst_loaded", loaded_o, 0);
        check("midrst_busy", busy_o, 0);
        check_frame("midrst_data", data_in_o, '0);
        launch();
        clear_errors();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
